// File: rtl/mesi_isc_mbus_ctrl_if.sv
// Bundles the CPU-side request handshake and the mesi_isc main-bus signals
// for the four ports of mesi_isc_mbus_ctrl.
interface mesi_isc_mbus_ctrl_if #(
    parameter int MBUS_CMD_WIDTH = 3,
    parameter int ADDR_WIDTH     = 32
);
    logic                        pause;
    logic [3:0]                  req_valid;
    logic [4*MBUS_CMD_WIDTH-1:0] req_cmd;
    logic [4*ADDR_WIDTH-1:0]     req_addr;
    logic [3:0]                  req_ready;
    logic [3:0]                  mbus_ack;
    logic [4*MBUS_CMD_WIDTH-1:0] mbus_cmd;
    logic [4*ADDR_WIDTH-1:0]     mbus_addr;
    logic [3:0]                  done;
    logic [3:0]                  timeout;
    logic                        busy;

    modport slave (
        input  pause, req_valid, req_cmd, req_addr, mbus_ack,
        output req_ready, mbus_cmd, mbus_addr, done, timeout, busy
    );

    modport master (
        output pause, req_valid, req_cmd, req_addr, mbus_ack,
        input  req_ready, mbus_cmd, mbus_addr, done, timeout, busy
    );
endinterface

// File: rtl/mesi_isc_mbus_ctrl.sv
// Per-CPU main-bus request sequencer in front of mesi_isc: holds each command
// until acked, inserts the mandatory NOP gap, and flags ports that never get an ack.
module mesi_isc_mbus_ctrl #(
    parameter int MBUS_CMD_WIDTH = 3,
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_WIDTH  = 8,
    parameter int TIMEOUT_CYCLES = 200
) (
    input logic                clk,
    input logic                rst,
    mesi_isc_mbus_ctrl_if.slave bus
);

    localparam logic [MBUS_CMD_WIDTH-1:0] CMD_NOP      = MBUS_CMD_WIDTH'(0);
    localparam logic [MBUS_CMD_WIDTH-1:0] CMD_WR       = MBUS_CMD_WIDTH'(1);
    localparam logic [MBUS_CMD_WIDTH-1:0] CMD_RD_BROAD = MBUS_CMD_WIDTH'(4);
    localparam logic [TIMEOUT_WIDTH-1:0]  TIMEOUT_MAX  = TIMEOUT_WIDTH'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        GAP
    } state_t;

    state_t                    state_q [4];
    state_t                    state_d [4];
    logic [MBUS_CMD_WIDTH-1:0] cmd_q   [4];
    logic [MBUS_CMD_WIDTH-1:0] cmd_d   [4];
    logic [ADDR_WIDTH-1:0]     addr_q  [4];
    logic [ADDR_WIDTH-1:0]     addr_d  [4];
    logic [TIMEOUT_WIDTH-1:0]  cnt_q   [4];
    logic [TIMEOUT_WIDTH-1:0]  cnt_d   [4];
    logic [3:0]                timeout_q;
    logic [3:0]                timeout_d;
    logic [3:0]                ready;
    logic [3:0]                done;
    logic                      busy;

    function automatic logic is_legal(input logic [MBUS_CMD_WIDTH-1:0] c);
        return (c >= CMD_WR) && (c <= CMD_RD_BROAD);
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                state_q[i] <= IDLE;
                cmd_q[i]   <= CMD_NOP;
                addr_q[i]  <= '0;
                cnt_q[i]   <= '0;
            end
            timeout_q <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                state_q[i] <= state_d[i];
                cmd_q[i]   <= cmd_d[i];
                addr_q[i]  <= addr_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            timeout_q <= timeout_d;
        end
    end

    // Ready is also gated by rst so nothing appears accepted while the block is held in reset.
    always_comb begin
        timeout_d = timeout_q;
        ready     = '0;
        done      = '0;
        busy      = 1'b0;
        for (int i = 0; i < 4; i++) begin
            state_d[i] = state_q[i];
            cmd_d[i]   = cmd_q[i];
            addr_d[i]  = addr_q[i];
            cnt_d[i]   = cnt_q[i];
            busy       = busy | (state_q[i] != IDLE);
            case (state_q[i])
                IDLE: begin
                    ready[i] = !bus.pause && !rst;
                    if (bus.req_valid[i] && ready[i] &&
                        is_legal(bus.req_cmd[i*MBUS_CMD_WIDTH +: MBUS_CMD_WIDTH])) begin
                        state_d[i] = ISSUE;
                        cmd_d[i]   = bus.req_cmd[i*MBUS_CMD_WIDTH +: MBUS_CMD_WIDTH];
                        addr_d[i]  = bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                        cnt_d[i]   = '0;
                    end
                end
                ISSUE: begin
                    if (bus.mbus_ack[i]) begin
                        done[i]    = 1'b1;
                        state_d[i] = GAP;
                        cmd_d[i]   = CMD_NOP;
                        addr_d[i]  = '0;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] != TIMEOUT_MAX) begin
                        cnt_d[i] = cnt_q[i] + 1'b1;
                        if (cnt_d[i] == TIMEOUT_MAX) begin
                            timeout_d[i] = 1'b1;
                        end
                    end
                end
                GAP: begin
                    state_d[i] = IDLE;
                end
                default: begin
                    state_d[i] = IDLE;
                end
            endcase
        end
    end

    for (genvar g = 0; g < 4; g++) begin : g_pack
        assign bus.mbus_cmd[g*MBUS_CMD_WIDTH +: MBUS_CMD_WIDTH] = cmd_q[g];
        assign bus.mbus_addr[g*ADDR_WIDTH +: ADDR_WIDTH]        = addr_q[g];
    end

    assign bus.req_ready = ready;
    assign bus.done      = done;
    assign bus.timeout   = timeout_q;
    assign bus.busy      = busy;

endmodule

// File: tb/tb_mesi_isc_mbus_ctrl.sv
// Directed and random stimulus for mesi_isc_mbus_ctrl, checked every cycle against
// a transaction-level model of each port (outstanding request, gap, wait count).
module tb_mesi_isc_mbus_ctrl;

    localparam int TIMEOUT = 200;
    localparam logic [2:0] NOP = 3'd0, WR = 3'd1, RD = 3'd2, WRB = 3'd3, RDB = 3'd4;

    logic clk;
    logic rst;

    mesi_isc_mbus_ctrl_if #(.MBUS_CMD_WIDTH(3), .ADDR_WIDTH(32)) bus_if ();

    mesi_isc_mbus_ctrl #(
        .MBUS_CMD_WIDTH(3),
        .ADDR_WIDTH(32),
        .TIMEOUT_WIDTH(8),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic         d_rst;
    logic         d_pause;
    logic [3:0]   d_valid;
    logic [11:0]  d_cmd;
    logic [127:0] d_addr;
    logic [3:0]   d_ack;

    bit          m_pending [4];
    bit          m_gap     [4];
    logic [2:0]  m_cmd     [4];
    logic [31:0] m_addr    [4];
    int          m_waited  [4];
    bit          m_to      [4];

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_pending[i] = 0;
            m_gap[i]     = 0;
            m_cmd[i]     = NOP;
            m_addr[i]    = '0;
            m_waited[i]  = 0;
            m_to[i]      = 0;
        end
    endtask

    // One clock edge worth of transactions: acks retire, gaps expire, legal requests start.
    task automatic model_advance();
        logic [2:0] c;
        if (rst) begin
            model_reset();
            return;
        end
        for (int i = 0; i < 4; i++) begin
            c = bus_if.req_cmd[i*3 +: 3];
            if (m_pending[i]) begin
                if (bus_if.mbus_ack[i]) begin
                    m_pending[i] = 0;
                    m_gap[i]     = 1;
                    m_waited[i]  = 0;
                end else begin
                    if (m_waited[i] < TIMEOUT) m_waited[i]++;
                    if (m_waited[i] == TIMEOUT) m_to[i] = 1;
                end
            end else if (m_gap[i]) begin
                m_gap[i] = 0;
            end else if (bus_if.req_valid[i] && !bus_if.pause && c >= 3'd1 && c <= 3'd4) begin
                m_pending[i] = 1;
                m_cmd[i]     = c;
                m_addr[i]    = bus_if.req_addr[i*32 +: 32];
                m_waited[i]  = 0;
            end
        end
    endtask

    task automatic checkOutput();
        logic [3:0]   exp_ready, exp_done, exp_to;
        logic [11:0]  exp_cmd;
        logic [127:0] exp_addr;
        logic         exp_busy;
        exp_ready = '0; exp_done = '0; exp_to = '0;
        exp_cmd = '0; exp_addr = '0; exp_busy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            exp_ready[i] = !rst && !bus_if.pause && !m_pending[i] && !m_gap[i];
            exp_done[i]  = m_pending[i] && bus_if.mbus_ack[i];
            exp_to[i]    = m_to[i];
            if (m_pending[i]) begin
                exp_cmd[i*3 +: 3]   = m_cmd[i];
                exp_addr[i*32 +: 32] = m_addr[i];
            end
            exp_busy = exp_busy | m_pending[i] | m_gap[i];
        end
        checks++;
        assert (bus_if.req_ready === exp_ready) else begin
            errors++;
            $error("[TB] FAIL ready @%0t: got %h expected %h", $time, bus_if.req_ready, exp_ready);
        end
        checks++;
        assert (bus_if.done === exp_done) else begin
            errors++;
            $error("[TB] FAIL done @%0t: got %h expected %h", $time, bus_if.done, exp_done);
        end
        checks++;
        assert (bus_if.mbus_cmd === exp_cmd) else begin
            errors++;
            $error("[TB] FAIL cmd @%0t: got %h expected %h", $time, bus_if.mbus_cmd, exp_cmd);
        end
        checks++;
        assert (bus_if.mbus_addr === exp_addr) else begin
            errors++;
            $error("[TB] FAIL addr @%0t: got %h expected %h", $time, bus_if.mbus_addr, exp_addr);
        end
        checks++;
        assert (bus_if.timeout === exp_to) else begin
            errors++;
            $error("[TB] FAIL timeout @%0t: got %h expected %h", $time, bus_if.timeout, exp_to);
        end
        checks++;
        assert (bus_if.busy === exp_busy) else begin
            errors++;
            $error("[TB] FAIL busy @%0t: got %b expected %b", $time, bus_if.busy, exp_busy);
        end
    endtask

    // Drives the current d_* values for n cycles, checking mid-cycle and advancing the model at each edge.
    task automatic applyStimulus(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            rst                = d_rst;
            bus_if.pause       = d_pause;
            bus_if.req_valid   = d_valid;
            bus_if.req_cmd     = d_cmd;
            bus_if.req_addr    = d_addr;
            bus_if.mbus_ack    = d_ack;
            #1;
            if (rst) model_reset();
            checkOutput();
            @(posedge clk);
            model_advance();
        end
    endtask

    task automatic set_req(input int p, input logic v, input logic [2:0] c, input logic [31:0] a);
        d_valid[p]       = v;
        d_cmd[p*3 +: 3]   = c;
        d_addr[p*32 +: 32] = a;
    endtask

    initial begin
        rst = 1'b1;
        bus_if.pause = 1'b0; bus_if.req_valid = '0; bus_if.req_cmd = '0;
        bus_if.req_addr = '0; bus_if.mbus_ack = '0;
        d_rst = 1'b1; d_pause = 1'b0; d_valid = '0; d_cmd = '0; d_addr = '0; d_ack = '0;
        model_reset();

        $display("[TB] reset");
        applyStimulus(2);
        d_rst = 1'b0;
        applyStimulus(1);

        $display("[TB] single RD on CPU0");
        set_req(0, 1'b1, RD, 32'h0000_1000);
        applyStimulus(1);
        set_req(0, 1'b0, 3'($urandom_range(0, 7)), $urandom);
        applyStimulus(3);
        d_ack[0] = 1'b1;
        applyStimulus(1);
        d_ack = '0;
        applyStimulus(3);

        $display("[TB] four simultaneous WR_BROAD");
        for (int p = 0; p < 4; p++) set_req(p, 1'b1, WRB, 32'h10 * (p + 1));
        applyStimulus(1);
        d_valid = '0;
        d_ack = 4'b0100; applyStimulus(1);
        d_ack = 4'b0001; applyStimulus(1);
        d_ack = 4'b1000; applyStimulus(1);
        d_ack = 4'b0010; applyStimulus(1);
        d_ack = '0;
        applyStimulus(3);

        $display("[TB] CPU2 timeout then late ack");
        set_req(2, 1'b1, WR, $urandom);
        applyStimulus(1);
        d_valid = '0;
        applyStimulus(TIMEOUT + 5);
        d_ack[2] = 1'b1;
        applyStimulus(1);
        d_ack = '0;
        applyStimulus(3);

        $display("[TB] pause with CPU1 in flight");
        set_req(1, 1'b1, RD, $urandom);
        applyStimulus(1);
        d_valid = '0;
        d_pause = 1'b1;
        set_req(3, 1'b1, RDB, $urandom);
        applyStimulus(3);
        d_ack[1] = 1'b1;
        applyStimulus(1);
        d_ack = '0;
        applyStimulus(3);
        d_pause = 1'b0;
        applyStimulus(1);
        d_valid = '0;
        applyStimulus(2);
        d_ack[3] = 1'b1;
        applyStimulus(1);
        d_ack = '0;
        applyStimulus(2);

        $display("[TB] NOP and illegal commands dropped");
        set_req(0, 1'b1, NOP, $urandom);
        applyStimulus(1);
        set_req(0, 1'b1, 3'd6, $urandom);
        applyStimulus(1);
        d_valid = '0;
        applyStimulus(2);

        $display("[TB] reset mid-transaction");
        set_req(3, 1'b1, RDB, $urandom);
        applyStimulus(1);
        d_valid = '0;
        applyStimulus(2);
        d_rst = 1'b1;
        applyStimulus(2);
        d_rst = 1'b0;
        applyStimulus(1);
        set_req(3, 1'b1, WR, $urandom);
        applyStimulus(1);
        d_valid = '0;
        applyStimulus(2);
        d_ack[3] = 1'b1;
        applyStimulus(1);
        d_ack = '0;
        applyStimulus(2);

        $display("[TB] random traffic");
        for (int k = 0; k < 400; k++) begin
            d_pause = ($urandom_range(0, 9) == 0);
            for (int p = 0; p < 4; p++) begin
                set_req(p, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom);
                d_ack[p] = ($urandom_range(0, 2) == 0);
            end
            applyStimulus(1);
        end
        d_valid = '0; d_ack = '0; d_pause = 1'b0;
        applyStimulus(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
